// File: rtl/project1_operand_sequencer.sv
// Operand sequencer for the 4-input evaluator: serial operand load or full
// 16-combination sweep, then a sampled result handed off with valid/ready.
module project1_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sweep,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             b_in,
  output logic             x1,
  output logic             x2,
  output logic             y1,
  output logic             y2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_b,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshake: res_valid is high for every cycle in RESULT; a cycle with
  // res_valid=1 and res_ready=1 transfers the result and returns to IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(16);

  state_e           state_q, state_d;
  logic [3:0]       ops_q, ops_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             mode_q, mode_d;
  logic             res_b_q, res_b_d;
  logic [CNT_W-1:0] ones_q, ones_d;

  always_comb begin
    state_d      = state_q;
    ops_d        = ops_q;
    bit_cnt_d    = bit_cnt_q;
    idx_d        = idx_q;
    settle_cnt_d = '0;
    mode_d       = mode_q;
    res_b_d      = res_b_q;
    ones_d       = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sweep) begin
            mode_d  = 1'b1;
            idx_d   = '0;
            ops_d   = '0;
            ones_d  = '0;
            res_b_d = 1'b0;
            state_d = S_SETTLE;
          end else begin
            mode_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // First accepted bit lands in x1 (ops bit 3), last in y2 (ops bit 0).
        if (ser_valid) begin
          ops_d[~bit_cnt_q] = ser_in;
          bit_cnt_d         = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
        else settle_cnt_d = settle_cnt_q + 4'd1;
      end
      S_SAMPLE: begin
        if (mode_q) begin
          if (ones_q != CNT_MAX) ones_d = ones_q + CNT_W'(b_in);
          res_b_d = res_b_q | b_in;
          if (idx_q == 4'd15) begin
            state_d = S_RESULT;
          end else begin
            idx_d   = idx_q + 4'd1;
            ops_d   = idx_q + 4'd1;
            state_d = S_SETTLE;
          end
        end else begin
          res_b_d = b_in;
          ones_d  = CNT_W'(b_in);
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ops_q        <= '0;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      mode_q       <= 1'b0;
      res_b_q      <= 1'b0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      ops_q        <= ops_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      mode_q       <= mode_d;
      res_b_q      <= res_b_d;
      ones_q       <= ones_d;
    end
  end

  assign {x1, x2, y1, y2} = ops_q;
  assign res_valid        = (state_q == S_RESULT);
  assign busy             = (state_q != S_IDLE);
  assign res_b            = res_b_q;
  assign ones_cnt         = ones_q;
  assign dbg_state        = state_q;

endmodule

// File: doc/project1_operand_sequencer.md
Name: project1_operand_sequencer

Overview:
- Sequential stage directly upstream of the 4-input Task 1 combinational evaluator (inputs x1, x2, y1, y2; output b).
- Serial mode: assembles one operand set from a serial bit stream, holds it stable through a settle window, then samples b and hands the result off with valid/ready.
- Sweep mode: applies all 16 input combinations in turn and counts how many produce b=1, giving hardware truth-table coverage of the evaluator.

Parameters:
- SETTLE_CYCLES, 1, cycles operands are held stable before b is sampled (legal range 1..15).
- CNT_W, 5, width of ones_cnt (must hold 0..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- sweep  input  1  mode select, sampled with start: 0=serial, 1=sweep.
- ser_in  input  1  serial operand bit.
- ser_valid  input  1  ser_in valid this cycle (LOAD only).
- b_in  input  1  evaluator output b.
- x1, x2, y1, y2  output  1 each  registered operands to the evaluator.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_b  output  1  serial mode: sampled b. Sweep mode: OR of all 16 samples.
- ones_cnt  output  CNT_W  sweep mode: count of b=1 samples. Serial mode: 0 or 1.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - x1, x2, y1, y2, res_valid, res_b, ones_cnt and busy all clear to 0.
  - Internal bit counter, sweep index and settle counter clear to 0.
- States: IDLE, LOAD, SETTLE, SAMPLE, RESULT.
- IDLE:
  - start=1, sweep=0 -> LOAD; bit counter cleared.
  - start=1, sweep=1 -> SETTLE; idx=0, operands={x1,x2,y1,y2}=4'b0000, ones_cnt=0, res_b=0.
  - start in any other state is ignored.
- LOAD:
  - Each cycle with ser_valid=1 shifts in one bit, in order x1, x2, y1, y2, and the operand output updates that cycle.
  - ser_valid=0 stalls the load; nothing changes.
  - After the 4th accepted bit -> SETTLE.
- SETTLE:
  - Operands held constant.
  - After exactly SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE (one cycle): registers b_in.
  - Serial: res_b=b_in, ones_cnt=b_in -> RESULT.
  - Sweep: ones_cnt+=b_in, res_b|=b_in.
    - If idx==15 -> RESULT.
    - Otherwise idx+=1, operands={x1,x2,y1,y2}=idx (x1=MSB, y2=LSB) -> SETTLE.
- RESULT:
  - res_valid=1; res_b and ones_cnt held stable.
  - res_ready=1 (same cycle allowed) -> IDLE; res_valid drops the next cycle.
- Latency:
  - Serial: 4 accepted bits + SETTLE_CYCLES + 1 to res_valid.
  - Sweep: 16*(SETTLE_CYCLES+1) cycles from start acceptance to res_valid.
- Operand, res_b and ones_cnt registers keep their last values in IDLE and change only as described above.
- ones_cnt never wraps: its maximum value is 16.
- A reset asserted mid-load or mid-sweep aborts the operation. No partial result is ever presented.

Test Plan:
- Reset mid-sweep at cycle 10 -> all outputs 0 on the same edge, busy=0; a later start operates normally.
- Serial load of 1,1,0,0 with SETTLE_CYCLES=1, b_in=0 model -> x1=1,x2=1,y1=0,y2=0; res_valid 6 cycles after start acceptance; res_b=0, ones_cnt=0.
- Serial load with ser_valid toggling every other cycle -> only valid bits accepted, final operands correct, res_valid delayed by 3 cycles.
- Sweep with b_in tied to 1 -> ones_cnt=16, res_b=1, res_valid at cycle 32 (SETTLE_CYCLES=1).
- Sweep with bench model b_in=x1&y1 -> ones_cnt=4, res_b=1. Sweep with b_in=0 -> ones_cnt=0, res_b=0.
- Hold res_ready=0 for 5 cycles in RESULT -> res_valid and values stable, start ignored; res_ready=1 -> IDLE next cycle, busy=0.
